// File: rtl/dmem_arbiter.sv
// Two-port req/gnt arbiter sharing one Data_Memory access port (port 0 CPU, port 1 debug/loader).
// Latency: req seen at edge N -> gnt in cycle N+1 -> rvalid/rdata in cycle N+2; one access per cycle.
// Backpressure: a requester holds req with stable fields until gnt; the loser simply keeps waiting.
module dmem_arbiter #(
   parameter int DEPTH    = 8,
   parameter int MAX_WAIT = 4,
   parameter int RR_MODE  = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [15:0] addr0,
   input  logic [15:0] addr1,
   input  logic [15:0] wdata0,
   input  logic [15:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        err0,
   output logic        err1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [15:0] rdata0,
   output logic [15:0] rdata1,
   output logic [15:0] mem_access_addr,
   output logic [15:0] mem_write_data,
   output logic        mem_write_en,
   output logic        mem_read,
   input  logic [15:0] mem_read_data
);

   localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1} state_t;

   state_t        state_q, state_d;
   logic          acc_we_q, acc_we_d;
   logic [15:0]   acc_addr_q, acc_addr_d;
   logic [15:0]   acc_wdata_q, acc_wdata_d;
   logic [WW-1:0] wait_cnt_q, wait_cnt_d;
   logic          rr_last_q, rr_last_d;
   logic          rvalid0_q, rvalid0_d;
   logic          rvalid1_q, rvalid1_d;
   logic [15:0]   rdata0_q, rdata0_d;
   logic [15:0]   rdata1_q, rdata1_d;

   logic          p0_wins;
   logic          pick0;
   logic          pick1;
   logic          in_range;
   logic [15:0]   rd_val;

   // Captured address is checked once; out-of-range accesses still grant but never touch memory.
   assign in_range = (acc_addr_q < 16'(DEPTH));
   assign rd_val   = in_range ? mem_read_data : 16'h0;

   // Arbitration, capture of the winner, starvation counter and round-robin pointer.
   always_comb begin
      state_d     = IDLE;
      acc_we_d    = acc_we_q;
      acc_addr_d  = acc_addr_q;
      acc_wdata_d = acc_wdata_q;
      wait_cnt_d  = wait_cnt_q;
      rr_last_d   = rr_last_q;

      if (RR_MODE != 0) begin
         p0_wins = rr_last_q;
      end else begin
         p0_wins = (wait_cnt_q != WW'(MAX_WAIT));
      end
      pick0 = req0 & (~req1 | p0_wins);
      pick1 = req1 & ~pick0;

      if (pick0) begin
         state_d     = ACC0;
         acc_we_d    = we0;
         acc_addr_d  = addr0;
         acc_wdata_d = wdata0;
         rr_last_d   = 1'b0;
      end else if (pick1) begin
         state_d     = ACC1;
         acc_we_d    = we1;
         acc_addr_d  = addr1;
         acc_wdata_d = wdata1;
         rr_last_d   = 1'b1;
      end

      if (~req1 | pick1) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q != WW'(MAX_WAIT)) begin
         wait_cnt_d = wait_cnt_q + WW'(1);
      end

      rvalid0_d = (state_q == ACC0) & ~acc_we_q;
      rvalid1_d = (state_q == ACC1) & ~acc_we_q;
      rdata0_d  = rvalid0_d ? rd_val : rdata0_q;
      rdata1_d  = rvalid1_d ? rd_val : rdata1_q;
   end

   // State and capture registers; reset drops any access in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_we_q    <= 1'b0;
         acc_addr_q  <= 16'h0;
         acc_wdata_q <= 16'h0;
         wait_cnt_q  <= '0;
         rr_last_q   <= 1'b1;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         rdata0_q    <= 16'h0;
         rdata1_q    <= 16'h0;
      end else begin
         state_q     <= state_d;
         acc_we_q    <= acc_we_d;
         acc_addr_q  <= acc_addr_d;
         acc_wdata_q <= acc_wdata_d;
         wait_cnt_q  <= wait_cnt_d;
         rr_last_q   <= rr_last_d;
         rvalid0_q   <= rvalid0_d;
         rvalid1_q   <= rvalid1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
      end
   end

   // Grant/strobe outputs are gated by rst so a reset cycle never issues a write.
   assign gnt0            = (state_q == ACC0) & ~rst;
   assign gnt1            = (state_q == ACC1) & ~rst;
   assign err0            = gnt0 & ~in_range;
   assign err1            = gnt1 & ~in_range;
   assign mem_write_en    = (state_q != IDLE) & acc_we_q & in_range & ~rst;
   assign mem_read        = (state_q != IDLE) & ~acc_we_q & in_range & ~rst;
   assign mem_access_addr = acc_addr_q;
   assign mem_write_data  = acc_wdata_q;
   assign rvalid0         = rvalid0_q;
   assign rvalid1         = rvalid1_q;
   assign rdata0          = rdata0_q;
   assign rdata1          = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: fixed-priority instance with a memory model, plus a round-robin instance.
// Inputs change 1 time unit after posedge; outputs are checked at the same point, away from the edge.
// Memory model is written only through the DUT's write strobe, except for a one-time preset.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, we0, we1;
   logic [15:0] addr0, addr1, wdata0, wdata1;

   logic        gnt0, gnt1, err0, err1, rvalid0, rvalid1;
   logic [15:0] rdata0, rdata1, mem_access_addr, mem_write_data, mem_read_data;
   logic        mem_write_en, mem_read;

   logic        r_gnt0, r_gnt1, r_err0, r_err1, r_rvalid0, r_rvalid1;
   logic [15:0] r_rdata0, r_rdata1, r_mem_addr, r_mem_wdata;
   logic        r_mem_we, r_mem_rd;
   logic [15:0] r_mem_rdata;

   logic [15:0] mem [16];
   logic        mem_clr;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.DEPTH(8), .MAX_WAIT(4), .RR_MODE(0)) u_dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .err0(err0), .err1(err1),
      .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
      .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
      .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
   );

   dmem_arbiter #(.DEPTH(8), .MAX_WAIT(4), .RR_MODE(1)) u_rr (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(r_gnt0), .gnt1(r_gnt1), .err0(r_err0), .err1(r_err1),
      .rvalid0(r_rvalid0), .rvalid1(r_rvalid1), .rdata0(r_rdata0), .rdata1(r_rdata1),
      .mem_access_addr(r_mem_addr), .mem_write_data(r_mem_wdata),
      .mem_write_en(r_mem_we), .mem_read(r_mem_rd), .mem_read_data(r_mem_rdata)
   );

   assign r_mem_rdata   = 16'h0;
   assign mem_read_data = mem[mem_access_addr[3:0]];

   // Data_Memory model: preset pattern 16'h5A00+i, then writes only via the DUT strobe.
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 16; i++) mem[i] <= 16'h5A00 + 16'(i);
      end else if (mem_write_en) begin
         mem[mem_access_addr[3:0]] <= mem_write_data;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
   endtask

   // Expected grant-to-port-1 sequences: req1 alone first, then both held.
   logic [10:0] exp_fix = 11'b10000100001; // bit 10 = first cycle
   logic [10:0] exp_rr  = 11'b10101010101;

   initial begin
      idle_inputs();
      rst = 1; mem_clr = 1;
      step();
      mem_clr = 0;
      step();
      rst = 0;

      // Reset values.
      chk("rst_gnt",    {30'h0, gnt1, gnt0}, 32'h0);
      chk("rst_err",    {30'h0, err1, err0}, 32'h0);
      chk("rst_rvalid", {30'h0, rvalid1, rvalid0}, 32'h0);
      chk("rst_rdata",  {rdata1, rdata0}, 32'h0);
      chk("rst_mem",    {mem_access_addr, mem_write_data}, 32'h0);
      chk("rst_strb",   {30'h0, mem_write_en, mem_read}, 32'h0);

      // Contention: fixed priority with starvation guard vs round-robin.
      req1 = 1;
      for (int k = 0; k < 11; k++) begin
         step();
         req0 = 1;
         chk($sformatf("fix_gnt1_%0d", k), {31'h0, gnt1}, {31'h0, exp_fix[10-k]});
         chk($sformatf("fix_gnt0_%0d", k), {31'h0, gnt0}, {31'h0, ~exp_fix[10-k]});
         chk($sformatf("rr_gnt1_%0d", k),  {31'h0, r_gnt1}, {31'h0, exp_rr[10-k]});
         chk($sformatf("rr_gnt0_%0d", k),  {31'h0, r_gnt0}, {31'h0, ~exp_rr[10-k]});
      end
      idle_inputs();
      step();
      step();

      // Port 0 write A5A5 to addr 3.
      req0 = 1; we0 = 1; addr0 = 3; wdata0 = 16'hA5A5;
      step();
      chk("wr_gnt0", {31'h0, gnt0}, 32'h1);
      chk("wr_we",   {31'h0, mem_write_en}, 32'h1);
      chk("wr_bus",  {mem_access_addr, mem_write_data}, {16'd3, 16'hA5A5});
      idle_inputs();
      step();
      chk("wr_done", {30'h0, gnt0, mem_write_en}, 32'h0);
      chk("wr_mem3", {16'h0, mem[3]}, 32'hA5A5);
      chk("idle_hold_addr", {16'h0, mem_access_addr}, 32'd3);

      // Port 0 read addr 3.
      req0 = 1; addr0 = 3;
      step();
      chk("rd_gnt0", {30'h0, gnt0, mem_read}, 32'h3);
      chk("rd_noval", {31'h0, rvalid0}, 32'h0);
      idle_inputs();
      step();
      chk("rd_rvalid0", {31'h0, rvalid0}, 32'h1);
      chk("rd_rdata0",  {16'h0, rdata0}, 32'hA5A5);
      step();
      chk("rd_rvalid_drop", {31'h0, rvalid0}, 32'h0);
      chk("rd_rdata_hold",  {16'h0, rdata0}, 32'hA5A5);

      // Back-to-back writes to addr 0,1,2, then back-to-back reads.
      req0 = 1; we0 = 1;
      for (int a = 0; a < 3; a++) begin
         addr0 = 16'(a); wdata0 = 16'h1110 + 16'(a);
         step();
         chk($sformatf("bbw_gnt_%0d", a), {31'h0, gnt0}, 32'h1);
      end
      idle_inputs();
      step();
      chk("bbw_mem", {mem[0][7:0], mem[1][7:0], mem[2][7:0], 8'h0}, 32'h10111200);

      req0 = 1; addr0 = 0;
      step();
      chk("bbr_c1", {30'h0, gnt0, rvalid0}, 32'h2);
      addr0 = 1;
      step();
      chk("bbr_c2", {30'h0, gnt0, rvalid0}, 32'h3);
      chk("bbr_d0", {16'h0, rdata0}, 32'h1110);
      addr0 = 2;
      step();
      chk("bbr_c3", {30'h0, gnt0, rvalid0}, 32'h3);
      chk("bbr_d1", {16'h0, rdata0}, 32'h1111);
      idle_inputs();
      step();
      chk("bbr_c4", {30'h0, gnt0, rvalid0}, 32'h1);
      chk("bbr_d2", {16'h0, rdata0}, 32'h1112);
      step();
      chk("bbr_c5", {30'h0, gnt0, rvalid0}, 32'h0);

      // Port 1 out-of-range write and read at addr 9.
      req1 = 1; we1 = 1; addr1 = 9; wdata1 = 16'hDEAD;
      step();
      chk("oor_w_flags", {29'h0, gnt1, err1, mem_write_en}, 32'h6);
      idle_inputs();
      step();
      chk("oor_w_mem9", {16'h0, mem[9]}, 32'h5A09);
      req1 = 1; addr1 = 9;
      step();
      chk("oor_r_flags", {29'h0, gnt1, err1, mem_read}, 32'h6);
      idle_inputs();
      step();
      chk("oor_r_rvalid", {31'h0, rvalid1}, 32'h1);
      chk("oor_r_rdata",  {16'h0, rdata1}, 32'h0);
      chk("oor_err_drop", {30'h0, err1, gnt1}, 32'h0);

      // Reset during an ACC1 write of 1234 to addr 2.
      req1 = 1; we1 = 1; addr1 = 2; wdata1 = 16'h1234;
      step();
      rst = 1;
      idle_inputs();
      #1;
      chk("rstmid_we", {30'h0, mem_write_en, gnt1}, 32'h0);
      step();
      rst = 0;
      chk("rstmid_mem2", {16'h0, mem[2]}, 32'h1112);
      chk("rstmid_gnt",  {28'h0, gnt1, gnt0, err1, err0}, 32'h0);
      chk("rstmid_bus",  {mem_access_addr, mem_write_data}, 32'h0);
      chk("rstmid_rd",   {rdata1, rdata0}, 32'h0);
      chk("rstmid_strb", {28'h0, mem_write_en, mem_read, rvalid1, rvalid0}, 32'h0);
      step();
      chk("rstmid_idle", {30'h0, gnt1, gnt0}, 32'h0);
      chk("rstmid_mem2b", {16'h0, mem[2]}, 32'h1112);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
